// File: rtl/hex_msg_pkg.sv
// Shared types and constants for the six-digit message scroller.
package hex_msg_pkg;

   localparam int unsigned CODE_W = 6;
   localparam int unsigned SEG_W  = 8;

   typedef enum logic [1:0] {
      ST_EDIT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   localparam logic [CODE_W-1:0] CH_A     = 6'd10;
   localparam logic [CODE_W-1:0] CH_BLANK = 6'd63;
   localparam logic [SEG_W-1:0]  SEG_BLANK = 8'hFF;

endpackage

// File: rtl/hex_msg_scroller_char_to_seg.sv
// Character code to active-low {dp,g,f,e,d,c,b,a} segment decode; dp is always off.
module char_to_seg
   import hex_msg_pkg::*;
(
   input  logic [CODE_W-1:0] code_i,
   output logic [SEG_W-1:0]  seg_c_o
);

   always_comb begin
      seg_c_o = SEG_BLANK;
      case (code_i)
         6'd0:  seg_c_o = 8'hC0;
         6'd1:  seg_c_o = 8'hF9;
         6'd2:  seg_c_o = 8'hA4;
         6'd3:  seg_c_o = 8'hB0;
         6'd4:  seg_c_o = 8'h99;
         6'd5:  seg_c_o = 8'h92;
         6'd6:  seg_c_o = 8'h82;
         6'd7:  seg_c_o = 8'hF8;
         6'd8:  seg_c_o = 8'h80;
         6'd9:  seg_c_o = 8'h90;
         CH_A:  seg_c_o = 8'h88;
         6'd11: seg_c_o = 8'h83;
         6'd12: seg_c_o = 8'hC6;
         6'd13: seg_c_o = 8'hA1;
         6'd14: seg_c_o = 8'h86;
         6'd15: seg_c_o = 8'h8E;
         6'd16: seg_c_o = 8'hC2;
         6'd17: seg_c_o = 8'h89;
         6'd18: seg_c_o = 8'hF9;
         6'd19: seg_c_o = 8'hE1;
         6'd20: seg_c_o = 8'h8A;
         6'd21: seg_c_o = 8'hC7;
         6'd22: seg_c_o = 8'hC8;
         6'd23: seg_c_o = 8'hAB;
         6'd24: seg_c_o = 8'hA3;
         6'd25: seg_c_o = 8'h8C;
         6'd26: seg_c_o = 8'h98;
         6'd27: seg_c_o = 8'hAF;
         6'd28: seg_c_o = 8'h92;
         6'd29: seg_c_o = 8'h87;
         6'd30: seg_c_o = 8'hC1;
         6'd31: seg_c_o = 8'hE3;
         6'd32: seg_c_o = 8'h81;
         6'd33: seg_c_o = 8'h89;
         6'd34: seg_c_o = 8'h91;
         6'd35: seg_c_o = 8'hA4;
         default: seg_c_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/hex_msg_scroller.sv
// Captures a switch-entered message and scrolls it right-to-left across HEX5..HEX0.
module hex_msg_scroller
   import hex_msg_pkg::*;
#(
   parameter int unsigned MSG_LEN    = 16,
   parameter int unsigned NUM_DIGITS = 6,
   parameter int unsigned TICK_DIV   = 25_000_000
) (
   input  logic                       CLOCK_50,
   input  logic                       RESET,
   input  logic [9:0]                 SW,
   input  logic                       WR,
   input  logic                       RUN,
   input  logic                       CLR,
   output logic [SEG_W-1:0]           HEX0,
   output logic [SEG_W-1:0]           HEX1,
   output logic [SEG_W-1:0]           HEX2,
   output logic [SEG_W-1:0]           HEX3,
   output logic [SEG_W-1:0]           HEX4,
   output logic [SEG_W-1:0]           HEX5,
   output logic [$clog2(MSG_LEN):0]   LEN,
   output logic                       FULL
);

   localparam int unsigned IDX_W = $clog2(MSG_LEN);
   localparam int unsigned LEN_W = IDX_W + 1;
   localparam int unsigned OFF_W = $clog2(MSG_LEN + NUM_DIGITS);
   localparam int unsigned SUM_W = OFF_W + 1;
   localparam int unsigned CNT_W = $clog2(TICK_DIV);

   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MSG_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   state_e              state_q, state_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic                full_q, full_d;
   logic [OFF_W-1:0]    off_q, off_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                wr_q;
   logic [CODE_W-1:0]   msg_q [MSG_LEN];
   logic [SEG_W-1:0]    hex_q [NUM_DIGITS];
   logic [SEG_W-1:0]    seg_c [NUM_DIGITS];

   logic                wr_rise_c;
   logic                wr_en_c;
   logic                tick_c;
   logic [SUM_W-1:0]    p_c;
   logic [SUM_W-1:0]    off_inc_c;
   logic [3:0]          unused_sw;

   assign unused_sw = SW[9:6];
   assign wr_rise_c = WR & ~wr_q;
   assign tick_c    = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
   assign p_c       = SUM_W'(len_q) + SUM_W'(NUM_DIGITS);
   assign off_inc_c = SUM_W'(off_q) + SUM_W'(1);

   // Next-state, buffer length, scroll offset and tick counter; CLR overrides all.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      off_d   = off_q;
      cnt_d   = cnt_q;
      wr_en_c = 1'b0;
      if (CLR) begin
         state_d = ST_EDIT;
         len_d   = '0;
         off_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_EDIT: begin
               if (wr_rise_c && (len_q != LEN_MAX)) begin
                  wr_en_c = 1'b1;
                  len_d   = len_q + LEN_W'(1);
               end
               if (RUN && (len_q != '0)) begin
                  state_d = ST_RUN;
                  off_d   = '0;
                  cnt_d   = '0;
               end
            end
            ST_RUN: begin
               if (tick_c) begin
                  cnt_d = '0;
                  off_d = (off_inc_c == p_c) ? '0 : off_q + OFF_W'(1);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               if (!RUN) state_d = ST_HOLD;
            end
            ST_HOLD: begin
               if (RUN) state_d = ST_RUN;
            end
            default: state_d = ST_EDIT;
         endcase
      end
      full_d = (len_d == LEN_MAX);
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_EDIT;
         len_q   <= '0;
         full_q  <= 1'b0;
         off_q   <= '0;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         full_q  <= full_d;
         off_q   <= off_d;
         cnt_q   <= cnt_d;
         wr_q    <= WR;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         for (int unsigned i = 0; i < MSG_LEN; i++) msg_q[i] <= CH_BLANK;
      end else if (wr_en_c) begin
         msg_q[IDX_W'(len_q)] <= SW[CODE_W-1:0];
      end
   end

   // Per-digit character select; digit 0 is HEX5 (leftmost).
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      localparam int unsigned RPOS = NUM_DIGITS - 1 - g;
      logic [SUM_W-1:0]  raw_c;
      logic [SUM_W-1:0]  run_idx_c;
      logic [CODE_W-1:0] code_c;

      assign raw_c     = SUM_W'(off_q) + SUM_W'(g);
      // offset+g < 2P, so one conditional subtract gives the modulo
      assign run_idx_c = (raw_c >= p_c) ? raw_c - p_c : raw_c;

      always_comb begin
         code_c = CH_BLANK;
         if (state_q == ST_EDIT) begin
            if (SUM_W'(RPOS) < SUM_W'(len_q))
               code_c = msg_q[IDX_W'(len_q - LEN_W'(RPOS + 1))];
         end else if (run_idx_c < SUM_W'(len_q)) begin
            code_c = msg_q[IDX_W'(run_idx_c)];
         end
      end

      char_to_seg u_char_to_seg (
         .code_i  (code_c),
         .seg_c_o (seg_c[g])
      );
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) hex_q[i] <= SEG_BLANK;
      end else begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) hex_q[i] <= seg_c[i];
      end
   end

   assign HEX5 = hex_q[0];
   assign HEX4 = hex_q[1];
   assign HEX3 = hex_q[2];
   assign HEX2 = hex_q[3];
   assign HEX1 = hex_q[4];
   assign HEX0 = hex_q[5];
   assign LEN  = len_q;
   assign FULL = full_q;

endmodule

// File: tb/tb_hex_msg_scroller.sv
// Scoreboard bench for hex_msg_scroller run with a 4-cycle scroll step.
module tb_hex_msg_scroller;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] sw;
   logic       wr, run, clr;
   logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;
   logic [4:0] len;
   logic       full;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string      tag;
      int         sel;
      logic [7:0] exp;
   } exp_t;

   exp_t sb_q[$];
   logic [5:0] msg_m [16];
   int         mlen_m;

   hex_msg_scroller #(.MSG_LEN(16), .NUM_DIGITS(6), .TICK_DIV(4)) dut (
      .CLOCK_50 (clk),
      .RESET    (rst),
      .SW       (sw),
      .WR       (wr),
      .RUN      (run),
      .CLR      (clr),
      .HEX0     (hex0),
      .HEX1     (hex1),
      .HEX2     (hex2),
      .HEX3     (hex3),
      .HEX4     (hex4),
      .HEX5     (hex5),
      .LEN      (len),
      .FULL     (full)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // sel 0..5 = HEXn, 6 = LEN, 7 = FULL
   function automatic logic [7:0] observe(input int sel);
      case (sel)
         0: return hex0;
         1: return hex1;
         2: return hex2;
         3: return hex3;
         4: return hex4;
         5: return hex5;
         6: return {3'b000, len};
         default: return {7'b0, full};
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [7:0] exp);
      exp_t e;
      e.tag = tag; e.sel = sel; e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic push_hex(input string tag, input logic [7:0] h5, input logic [7:0] h4,
                           input logic [7:0] h3, input logic [7:0] h2,
                           input logic [7:0] h1, input logic [7:0] h0);
      push({tag, " hex5"}, 5, h5);
      push({tag, " hex4"}, 4, h4);
      push({tag, " hex3"}, 3, h3);
      push({tag, " hex2"}, 2, h2);
      push({tag, " hex1"}, 1, h1);
      push({tag, " hex0"}, 0, h0);
   endtask

   task automatic drain();
      exp_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val(e.tag, observe(e.sel), e.exp);
      end
   endtask

   task automatic cycle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_char(input logic [5:0] code);
      sw = {4'b0000, code};
      wr = 1'b1;
      cycle(1);
      wr = 1'b0;
      cycle(1);
      if (mlen_m < 16) begin
         msg_m[mlen_m] = code;
         mlen_m++;
      end
   endtask

   task automatic do_clr();
      clr = 1'b1;
      cycle(1);
      clr = 1'b0;
      cycle(1);
      mlen_m = 0;
   endtask

   function automatic logic [7:0] seg_of(input logic [5:0] c);
      case (c)
         6'd17:   return 8'h89;
         6'd18:   return 8'hF9;
         default: return 8'hFF;
      endcase
   endfunction

   // Expected scroll frame: digit d (0 = HEX5) shows v[(off+d) mod P].
   task automatic push_frame(input string tag, input int off);
      int p, idx;
      logic [7:0] e;
      p = mlen_m + 6;
      for (int d = 0; d < 6; d++) begin
         idx = (off + d) % p;
         e = (idx < mlen_m) ? seg_of(msg_m[idx]) : 8'hFF;
         push($sformatf("%s d%0d", tag, d), 5 - d, e);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; sw = '0; wr = 1'b0; run = 1'b0; clr = 1'b0; mlen_m = 0;
      cycle(2);
      push_hex("rst", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      push("rst len", 6, 8'd0);
      push("rst full", 7, 8'd0);
      drain();
      rst = 1'b0;
      cycle(1);

      // RUN with an empty buffer must stay in EDIT
      run = 1'b1;
      cycle(5);
      push("empty run len", 6, 8'd0);
      push_hex("empty run", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      drain();
      run = 1'b0;
      cycle(1);
      write_char(6'd5);
      push("edit ok len", 6, 8'd1);
      push("edit ok hex0", 0, 8'h92);
      drain();
      do_clr();

      // write edge coincident with CLR
      clr = 1'b1; sw = 10'd7; wr = 1'b1;
      cycle(1);
      push("clr+wr len", 6, 8'd0);
      drain();
      clr = 1'b0; wr = 1'b0;
      cycle(2);
      push("clr+wr len2", 6, 8'd0);
      push("clr+wr hex0", 0, 8'hFF);
      drain();

      write_char(6'd17);
      write_char(6'd18);
      push("HI len", 6, 8'd2);
      push_hex("HI", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h89, 8'hF9);
      drain();

      sw = 10'd5; wr = 1'b1;
      cycle(10);
      wr = 1'b0;
      cycle(1);
      push("wr held len", 6, 8'd3);
      push_hex("wr held", 8'hFF, 8'hFF, 8'hFF, 8'h89, 8'hF9, 8'h92);
      drain();
      do_clr();

      for (int i = 0; i < 17; i++) write_char(6'(i));
      push("full len", 6, 8'd16);
      push("full flag", 7, 8'd1);
      push_hex("full", 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E);
      drain();
      do_clr();
      push("clr len", 6, 8'd0);
      push("clr full", 7, 8'd0);
      push("clr hex0", 0, 8'hFF);
      drain();

      write_char(6'd40);
      push("code40 len", 6, 8'd1);
      push("code40 hex0", 0, 8'hFF);
      drain();
      do_clr();

      // scroll "HI": step visible 4k+2 negedges after RUN is raised
      write_char(6'd17);
      write_char(6'd18);
      run = 1'b1;
      cycle(1);
      for (int k = 2; k <= 34; k++) begin
         cycle(1);
         push_frame($sformatf("scroll k%0d", k), (k - 2) / 4);
         drain();
      end

      // hold after two steps, then resume from the frozen counter
      run = 1'b0;
      do_clr();
      write_char(6'd17);
      write_char(6'd18);
      write_char(6'd17);
      write_char(6'd18);
      run = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         cycle(1);
         if (k >= 2) begin
            push_frame($sformatf("prehold k%0d", k), (k - 2) / 4);
            drain();
         end
      end
      run = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         cycle(1);
         push_frame($sformatf("hold k%0d", k), 2);
         drain();
      end
      run = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         cycle(1);
         push_frame($sformatf("resume j%0d", j), (j < 4) ? 2 : ((j < 8) ? 3 : 4));
         drain();
      end

      // asynchronous reset mid-scroll
      rst = 1'b1;
      #1;
      push_hex("midrst", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      push("midrst len", 6, 8'd0);
      push("midrst full", 7, 8'd0);
      drain();
      cycle(1);
      run = 1'b0;
      rst = 1'b0;
      mlen_m = 0;
      cycle(1);
      write_char(6'd17);
      push("post rst len", 6, 8'd1);
      push("post rst hex0", 0, 8'h89);
      push("post rst hex1", 1, 8'hFF);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
